arbitro_memoria: RTL and testbench
==================================

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles in ACCESS waiting for mem_ready before abort.
REQ-002 Parameter STARVE_MAX, default 3: max consecutive data grants while an instruction request waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_rdata  output  32  fetched instruction; valid while if_ack=1.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req  input  1  data-memory request (load/store); held until dm_ack.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_rdata  output  32  load data; valid while dm_ack=1.
REQ-014 dm_ack  output  1  one-cycle data completion pulse.
REQ-015 mem_en, mem_we  output  1 each  unified single-port memory strobe and write enable.
REQ-016 mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-017 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-018 mem_ready  input  1  memory completion for the current access.
REQ-019 stall_if, stall_mem  output  1 each  pipeline stall requests to fetch and memory stages.
REQ-020 err_timeout  output  1  sticky timeout flag.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; all memory-side outputs registered.
REQ-022 IDLE: no request -> stay IDLE; any request -> ACCESS, latching winner's address/data/we into mem_* registers, mem_en=1.
REQ-023 Arbitration: data wins on simultaneous requests unless starve counter == STARVE_MAX, then instruction wins.
REQ-024 Starve counter: +1 per data grant while if_req=1 (saturates at STARVE_MAX); cleared on any instruction grant or when if_req=0 at a grant.
REQ-025 Instruction grants always drive mem_we=0 regardless of dm_we.
REQ-026 ACCESS: mem_en held with stable mem_addr/mem_we/mem_wdata; mem_ready=1 at a clock edge -> RESP, mem_rdata latched into winner's rdata register.
REQ-027 ACCESS wait counter: counts cycles with mem_ready=0; reaching TIMEOUT -> RESP with rdata register = 32'h0000_0000, err_timeout set.
REQ-028 RESP: exactly one cycle; winner's ack=1, mem_en=0, mem_we=0; next state IDLE.
REQ-029 A request sampled in IDLE is always a new request; requester drops req the cycle after ack unless issuing another access.
REQ-030 Minimum latency: req first high in cycle N -> ACCESS in N+1 -> ack in N+2 if mem_ready=1 in N+1.
REQ-031 if_ack and dm_ack never asserted in the same cycle.
REQ-032 if_rdata/dm_rdata hold last value outside ack; only the granted requester's register updates.
REQ-033 stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack (combinational).
REQ-034 Requests changing during ACCESS/RESP are ignored until next IDLE.
REQ-035 err_timeout cleared only by reset.

Reset
REQ-036 reset=0 immediately forces IDLE; mem_en, mem_we, if_ack, dm_ack, err_timeout = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve and wait counters = 0.
REQ-037 Reset mid-ACCESS aborts the access without ack; after release first grant occurs from IDLE per REQ-022.

Verification
REQ-038 if_req=1, if_addr=0x10, mem_ready=1 next cycle, mem_rdata=0x8C220004 -> mem_en in N+1, if_ack with if_rdata=0x8C220004 in N+2, mem_we=0.
REQ-039 if_req and dm_req (dm_we=1, dm_addr=0x40, dm_wdata=0xCAFE) same cycle -> store granted first (mem_we=1, mem_addr=0x40), fetch granted on next IDLE, stall_if high throughout.
REQ-040 if_req held, dm_req reissued back-to-back, mem_ready immediate -> exactly 3 data grants, then instruction grant, then data.
REQ-041 Load, mem_ready held 0 -> after 8 wait cycles dm_ack=1, dm_rdata=0, err_timeout=1 and stays 1 until reset.
REQ-042 reset=0 asserted asynchronously mid-ACCESS -> mem_en=0 without clock edge, no ack; after release a pending dm_req is granted normally.

Source files
------------

// File: rtl/arbitro_memoria.sv
// Purpose : arbitrates a unified single-port memory between instruction fetch and data access.
// Latency : request seen in IDLE -> ACCESS next cycle -> ack one cycle after mem_ready (min 2 cycles).
// Backpressure: requesters hold req until their one-cycle ack; stall_if/stall_mem hold the pipeline meanwhile.
//
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_rdata/if_ack         instruction fetch side
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack   data side
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready   memory side (outputs registered)
//   stall_if, stall_mem, err_timeout (sticky)
module arbitro_memoria #(
    parameter int TIMEOUT    = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err_timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    // Last wait cycle before the access is abandoned.
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [1:0]          state_q,     state_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         dm_rdata_q,  dm_rdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                dm_ack_q,    dm_ack_d;
    logic                err_q,       err_d;
    logic                grant_if_q,  grant_if_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;

    logic                pick_if;
    logic                finish;
    logic [31:0]         resp_data;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;
        grant_if_d  = grant_if_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        pick_if     = 1'b0;
        finish      = 1'b0;
        resp_data   = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    // Data has priority except when fetch has been passed over too often.
                    pick_if    = if_req && (!dm_req || (starve_q == STARVE_LIM));
                    state_d    = ST_ACCESS;
                    mem_en_d   = 1'b1;
                    wait_d     = '0;
                    grant_if_d = pick_if;
                    if (pick_if) begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = 32'h0000_0000;
                        starve_d    = '0;
                    end else begin
                        mem_addr_d  = dm_addr;
                        mem_we_d    = dm_we;
                        mem_wdata_d = dm_wdata;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ready) begin
                    finish    = 1'b1;
                    resp_data = mem_rdata;
                end else if (wait_q == WAIT_LAST) begin
                    // Abandon the access: respond with zero data and flag it.
                    finish    = 1'b1;
                    resp_data = 32'h0000_0000;
                    err_d     = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end

                if (finish) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (grant_if_q) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = resp_data;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            if_rdata_q  <= 32'h0000_0000;
            dm_rdata_q  <= 32'h0000_0000;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            grant_if_q  <= 1'b0;
            starve_q    <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            grant_if_q  <= grant_if_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ack      = if_ack_q;
    assign dm_ack      = dm_ack_q;
    assign err_timeout = err_q;

    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: table-driven requests, a memory responder with
// programmable latency, and a scoreboard of expected grants/acks.
module tb_arbitro_memoria;

    localparam int TIMEOUT    = 8;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        err_timeout;

    arbitro_memoria #(
        .TIMEOUT    (TIMEOUT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_if;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        tmo;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          delay;
        logic        exp_first_if;
        int          exp_lat;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ready_delay = 0;

    exp_t        exp_q[$];
    exp_t        cur;
    logic        cur_vld = 1'b0;
    logic [31:0] exp_if_rd = 32'h0;
    logic [31:0] exp_dm_rd = 32'h0;
    logic        exp_err   = 1'b0;

    // Contents of the bench's memory: any read returns a value derived from the address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h8C22_0004;
        return (a ^ 32'hA5A5_0000) + 32'h1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic is_if, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic tmo, input int lat);
        exp_t e;
        e.is_if = is_if;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.tmo   = tmo;
        e.rdata = tmo ? 32'h0 : mem_model(addr);
        e.lat   = lat;
        e.t0    = cyc;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: raises mem_ready after ready_delay ACCESS cycles.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (wcnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                end
                wcnt++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt      = 0;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=addr %0h expected=no grant", mem_addr);
                end else begin
                    cur     = exp_q.pop_front();
                    cur_vld = 1'b1;
                    chk("grant_addr", mem_addr, cur.addr);
                    chk("grant_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
                end
            end
            prev_en = mem_en;

            if (if_ack || dm_ack) begin
                chk("ack_exclusive", 32'(if_ack & dm_ack), 32'h0);
                if (!cur_vld) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_ack actual=if_ack %0b dm_ack %0b expected=no ack", if_ack, dm_ack);
                end else begin
                    chk("ack_if", 32'(if_ack), 32'(cur.is_if));
                    chk("ack_dm", 32'(dm_ack), 32'(!cur.is_if));
                    if (cur.lat >= 0) chk("latency", 32'(cyc - cur.t0), 32'(cur.lat));
                    if (cur.is_if) exp_if_rd = cur.rdata;
                    else           exp_dm_rd = cur.rdata;
                    if (cur.tmo) exp_err = 1'b1;
                    cur_vld = 1'b0;
                end
            end

            chk("if_rdata", if_rdata, exp_if_rd);
            chk("dm_rdata", dm_rdata, exp_dm_rd);
            chk("err_timeout", 32'(err_timeout), 32'(exp_err));
            chk("stall_if", 32'(stall_if), 32'(if_req & ~if_ack));
            chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_ack));
        end
    end

    // Runs cycles until every raised request has been acknowledged, dropping each on its ack.
    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && (if_req || dm_req); n++) begin
            @(posedge clk);
            #1;
            if (if_ack) if_req = 1'b0;
            if (dm_ack) dm_req = 1'b0;
        end
        if (if_req || dm_req) begin
            checks++;
            failures++;
            $display("FAIL req_timeout actual=if_req %0b dm_req %0b expected=both acked", if_req, dm_req);
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk);
        #1;
        if_req      = v.ireq;
        if_addr     = v.iaddr;
        dm_req      = v.dreq;
        dm_we       = v.dwe;
        dm_addr     = v.daddr;
        dm_wdata    = v.dwdata;
        ready_delay = v.delay;
        if (v.ireq && v.dreq) begin
            if (v.exp_first_if) begin
                push_exp(1'b1, v.iaddr, 1'b0, 32'h0, 1'b0, v.exp_lat);
                push_exp(1'b0, v.daddr, v.dwe, v.dwdata, 1'b0, -1);
            end else begin
                push_exp(1'b0, v.daddr, v.dwe, v.dwdata, 1'b0, v.exp_lat);
                push_exp(1'b1, v.iaddr, 1'b0, 32'h0, 1'b0, -1);
            end
        end else if (v.ireq) begin
            push_exp(1'b1, v.iaddr, 1'b0, 32'h0, 1'b0, v.exp_lat);
        end else begin
            push_exp(1'b0, v.daddr, v.dwe, v.dwdata, 1'b0, v.exp_lat);
        end
        wait_done(60);
    endtask

    function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                                input int delay, input logic first_if, input int lat);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr;
        v.dwdata = dwdata; v.delay = delay; v.exp_first_if = first_if; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        vec_t vecs[6];
        int   dcnt;
        int   n;

        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        // ireq iaddr dreq dwe daddr wdata delay first_if lat
        vecs[0] = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,    0, 1'b1, 2);
        vecs[1] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,    0, 1'b0, 2);
        vecs[2] = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h40,  32'hCAFE, 1, 1'b0, 3);
        vecs[3] = mk(1'b1, 32'h14, 1'b0, 1'b1, 32'h44,  32'h1234, 2, 1'b1, 4);
        vecs[4] = mk(1'b1, 32'h18, 1'b1, 1'b1, 32'h40,  32'hCAFE, 0, 1'b0, 2);
        vecs[5] = mk(1'b1, 32'h1C, 1'b1, 1'b0, 32'h300, 32'h0,    3, 1'b0, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en",    32'(mem_en), 32'h0);
        chk("rst_mem_we",    32'(mem_we), 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_ack",    32'(if_ack), 32'h0);
        chk("rst_dm_ack",    32'(dm_ack), 32'h0);
        chk("rst_if_rdata",  if_rdata, 32'h0);
        chk("rst_dm_rdata",  dm_rdata, 32'h0);
        chk("rst_err",       32'(err_timeout), 32'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Fetch held while data requests keep arriving: three data grants, then fetch, then data.
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
        ready_delay = 0;
        push_exp(1'b0, 32'h600, 1'b0, 32'h0, 1'b0, 2);
        push_exp(1'b0, 32'h600, 1'b0, 32'h0, 1'b0, -1);
        push_exp(1'b0, 32'h600, 1'b0, 32'h0, 1'b0, -1);
        push_exp(1'b1, 32'h20,  1'b0, 32'h0, 1'b0, -1);
        push_exp(1'b0, 32'h600, 1'b0, 32'h0, 1'b0, -1);
        dcnt = 0;
        n    = 0;
        while ((if_req || dm_req) && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (if_ack) if_req = 1'b0;
            if (dm_ack) begin
                dcnt++;
                if (dcnt == 4) dm_req = 1'b0;
            end
        end
        chk("starve_done", 32'(if_req | dm_req), 32'h0);
        if_req = 1'b0;
        dm_req = 1'b0;

        // Load that never completes: abandoned after TIMEOUT wait cycles.
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
        ready_delay = 100;
        push_exp(1'b0, 32'h500, 1'b0, 32'h0, 1'b1, TIMEOUT + 1);
        wait_done(40);

        // A normal fetch afterwards; the error flag must stay set.
        apply_vec(mk(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 2));

        // Reset asserted between clock edges in the middle of an access.
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
        ready_delay = 100;
        push_exp(1'b0, 32'h700, 1'b0, 32'h0, 1'b0, -1);
        n = 0;
        while (!mem_en && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_access_started", 32'(mem_en), 32'h1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_mem_en",   32'(mem_en), 32'h0);
        chk("arst_mem_we",   32'(mem_we), 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_dm_ack",   32'(dm_ack), 32'h0);
        chk("arst_if_ack",   32'(if_ack), 32'h0);
        chk("arst_err",      32'(err_timeout), 32'h0);
        chk("arst_if_rdata", if_rdata, 32'h0);
        exp_err   = 1'b0;
        exp_if_rd = 32'h0;
        exp_dm_rd = 32'h0;
        cur_vld   = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        ready_delay = 0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        push_exp(1'b0, 32'h700, 1'b0, 32'h0, 1'b0, 2);
        wait_done(20);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("sb_no_open_txn", 32'(cur_vld), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
